// File: rtl/alu16_sequencer_if.sv
// rtl/alu16_sequencer_if.sv - bus between the 16-bit sequencer and the shared 8-bit ALU
interface alu16_sequencer_if;
  logic [7:0] alu_data0_out;
  logic [7:0] alu_data1_out;
  logic [4:0] alu_op_out;
  logic [3:0] alu_flags_out;
  logic       alu_size_out;
  logic [7:0] alu_result_in;
  logic [3:0] alu_flags_in;

  modport master (
    output alu_data0_out, alu_data1_out, alu_op_out, alu_flags_out, alu_size_out,
    input  alu_result_in, alu_flags_in
  );

  modport slave (
    input  alu_data0_out, alu_data1_out, alu_op_out, alu_flags_out, alu_size_out,
    output alu_result_in, alu_flags_in
  );
endinterface

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - two-pass 16-bit add/inc/dec/add-sp sequencer on the 8-bit ALU
module alu16_sequencer #(
  parameter int F_Z = 3,
  parameter int F_N = 2,
  parameter int F_H = 1,
  parameter int F_C = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [3:0]  flags_out,
  alu16_sequencer_if.master alu
);

  localparam logic [1:0] OP_ADD16 = 2'd0;
  localparam logic [1:0] OP_INC16 = 2'd1;
  localparam logic [1:0] OP_DEC16 = 2'd2;
  localparam logic [1:0] OP_ADDSP = 2'd3;

  // ALU opcode encodings shared with the CPU's ALU
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_ADC    = 5'd1;
  localparam logic [4:0] ALU_PASS0  = 5'd16;
  localparam logic       ALU_SIZE_8 = 1'b0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [7:0]  a_hi_q;
  logic [7:0]  b_hi_q;
  logic [3:0]  flags_q;
  logic [7:0]  res_lo;
  logic        c_lo;
  logic        h_lo;
  logic [15:0] b_eff;
  logic        accept;
  logic [4:0]  hi_op;
  logic [3:0]  flags_hi;

  // the 8-bit ALU always works byte-wide here
  assign alu.alu_size_out = ALU_SIZE_8;

  // new requests are only taken when no pass is in flight
  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  // high pass chains the low-pass carry by switching to ADC (a fixed +1)
  assign hi_op = alu.alu_flags_in[F_C] ? ALU_ADC : ALU_ADD;

  // second operand as seen by the two passes
  always_comb begin
    b_eff = b_in;
    case (op)
      OP_INC16: b_eff = 16'h0001;
      OP_DEC16: b_eff = 16'hFFFF;
      OP_ADDSP: b_eff = {{8{b_in[7]}}, b_in[7:0]};
      default:  b_eff = b_in;
    endcase
  end

  // final flag composition, evaluated while the high pass is on the ALU
  always_comb begin
    flags_hi = flags_q;
    case (op_q)
      OP_ADD16: begin
        flags_hi      = 4'b0000;
        flags_hi[F_Z] = flags_q[F_Z];
        flags_hi[F_N] = 1'b0;
        flags_hi[F_H] = alu.alu_flags_in[F_H];
        flags_hi[F_C] = alu.alu_flags_in[F_C];
      end
      OP_ADDSP: begin
        flags_hi      = 4'b0000;
        flags_hi[F_H] = h_lo;
        flags_hi[F_C] = c_lo;
      end
      default: flags_hi = flags_q;
    endcase
  end

  // pass sequencing; ALU drive values are registered one pass ahead
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      result            <= 16'h0000;
      flags_out         <= 4'h0;
      op_q              <= OP_ADD16;
      a_hi_q            <= 8'h00;
      b_hi_q            <= 8'h00;
      flags_q           <= 4'h0;
      res_lo            <= 8'h00;
      c_lo              <= 1'b0;
      h_lo              <= 1'b0;
      alu.alu_data0_out <= 8'h00;
      alu.alu_data1_out <= 8'h00;
      alu.alu_op_out    <= ALU_PASS0;
      alu.alu_flags_out <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state             <= ST_LOW;
            busy              <= 1'b1;
            op_q              <= op;
            a_hi_q            <= a_in[15:8];
            b_hi_q            <= b_eff[15:8];
            flags_q           <= flags_in;
            alu.alu_data1_out <= a_in[7:0];
            alu.alu_data0_out <= b_eff[7:0];
            alu.alu_op_out    <= ALU_ADD;
            alu.alu_flags_out <= flags_in;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOW: begin
          state             <= ST_HIGH;
          res_lo            <= alu.alu_result_in;
          c_lo              <= alu.alu_flags_in[F_C];
          h_lo              <= alu.alu_flags_in[F_H];
          alu.alu_data1_out <= a_hi_q;
          alu.alu_data0_out <= b_hi_q;
          alu.alu_op_out    <= hi_op;
        end
        ST_HIGH: begin
          state             <= ST_DONE;
          busy              <= 1'b0;
          done              <= 1'b1;
          result            <= {alu.alu_result_in, res_lo};
          flags_out         <= flags_hi;
          alu.alu_data0_out <= 8'h00;
          alu.alu_data1_out <= 8'h00;
          alu.alu_op_out    <= ALU_PASS0;
          alu.alu_flags_out <= 4'h0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb/tb_alu16_sequencer.sv - scoreboard bench for alu16_sequencer with an 8-bit ALU model
module tb_alu16_sequencer;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_ADC   = 5'd1;
  localparam logic [4:0] ALU_PASS0 = 5'd16;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  f;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  flags_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags_out;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp;
  int   n_bad;

  logic       cin;
  logic [8:0] sum9;
  logic [4:0] sum5;

  alu16_sequencer_if alu_bus ();

  alu16_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .flags_in  (flags_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .flags_out (flags_out),
    .alu       (alu_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 8-bit ALU: ADD, ADC as ADD plus one; flags ZNHC
  always_comb begin
    cin  = (alu_bus.alu_op_out == ALU_ADC);
    sum9 = {1'b0, alu_bus.alu_data1_out} + {1'b0, alu_bus.alu_data0_out} + {8'h00, cin};
    sum5 = {1'b0, alu_bus.alu_data1_out[3:0]} + {1'b0, alu_bus.alu_data0_out[3:0]} + {4'h0, cin};
    alu_bus.alu_result_in = sum9[7:0];
    alu_bus.alu_flags_in  = {(sum9[7:0] == 8'h00), 1'b0, sum5[4], sum9[8]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // monitor: every done pulse is matched against the oldest expectation
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        e = exp_q.pop_front();
        chk("result", {16'h0, result}, {16'h0, e.r});
        chk("flags_out", {28'h0, flags_out}, {28'h0, e.f});
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_result"}, {16'h0, result}, 32'h0);
    chk({tag, "_flags_out"}, {28'h0, flags_out}, 32'h0);
    chk({tag, "_data0"}, {24'h0, alu_bus.alu_data0_out}, 32'h0);
    chk({tag, "_data1"}, {24'h0, alu_bus.alu_data1_out}, 32'h0);
    chk({tag, "_alu_op"}, {27'h0, alu_bus.alu_op_out}, {27'h0, ALU_PASS0});
    chk({tag, "_alu_flags"}, {28'h0, alu_bus.alu_flags_out}, 32'h0);
    chk({tag, "_alu_size"}, {31'h0, alu_bus.alu_size_out}, 32'h0);
  endtask

  // one operation from IDLE, with per-cycle handshake and ALU-drive checks
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] f, input logic [15:0] er,
                        input logic [3:0] ef, input logic [4:0] hi_op);
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b; flags_in = f;
    exp_q.push_back('{r: er, f: ef});
    @(posedge clock);
    #1;
    start = 1'b0; op = 2'd2; a_in = 16'hDEAD; b_in = 16'hBEEF; flags_in = 4'hF;
    @(negedge clock);
    chk({tag, "_low_busy"}, {30'h0, busy, done}, 32'h2);
    chk({tag, "_low_op"}, {27'h0, alu_bus.alu_op_out}, {27'h0, ALU_ADD});
    chk({tag, "_low_data1"}, {24'h0, alu_bus.alu_data1_out}, {24'h0, a[7:0]});
    @(negedge clock);
    chk({tag, "_high_busy"}, {30'h0, busy, done}, 32'h2);
    chk({tag, "_high_op"}, {27'h0, alu_bus.alu_op_out}, {27'h0, hi_op});
    @(negedge clock);
    chk({tag, "_done_cycle"}, {30'h0, busy, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; start = 1'b0; op = 2'd0; a_in = 16'h0; b_in = 16'h0; flags_in = 4'h0;
    @(negedge clock);
    chk_idle("reset");
    @(negedge clock);
    reset_n = 1'b1;

    run_op("add_h",   2'd0, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, ALU_ADC);
    run_op("add_wrap",2'd0, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, ALU_ADC);
    run_op("inc",     2'd1, 16'h00FF, 16'h7777, 4'b0101, 16'h0100, 4'b0101, ALU_ADC);
    run_op("dec_wrap",2'd2, 16'h0000, 16'h7777, 4'b1010, 16'hFFFF, 4'b1010, ALU_ADD);
    run_op("dec",     2'd2, 16'h1234, 16'h0000, 4'b0000, 16'h1233, 4'b0000, ALU_ADC);
    run_op("addsp_n", 2'd3, 16'h0005, 16'h00FE, 4'b0000, 16'h0003, 4'b0011, ALU_ADC);
    run_op("addsp_p", 2'd3, 16'h1000, 16'h0001, 4'b1111, 16'h1001, 4'b0000, ALU_ADD);
    repeat (2) @(negedge clock);

    // start held high: three back-to-back ops, a stray INC during LOW is ignored
    start = 1'b1; op = 2'd0; a_in = 16'h0001; b_in = 16'h0001; flags_in = 4'h0;
    for (int i = 0; i < 3; i++) exp_q.push_back('{r: 16'h0002, f: 4'b0000});
    for (int it = 0; it < 3; it++) begin
      @(negedge clock);
      chk("b2b_low_busy", {30'h0, busy, done}, 32'h2);
      if (it == 0) begin
        op = 2'd1; a_in = 16'h5555;
      end
      @(negedge clock);
      op = 2'd0; a_in = 16'h0001;
      chk("b2b_high_busy", {30'h0, busy, done}, 32'h2);
      @(negedge clock);
      chk("b2b_done", {30'h0, busy, done}, 32'h1);
      if (it == 2) start = 1'b0;
    end
    @(negedge clock);
    chk("b2b_back_idle", {30'h0, busy, done}, 32'h0);

    // reset during the high pass aborts without a completion
    start = 1'b1; op = 2'd0; a_in = 16'h0FFF; b_in = 16'h0001; flags_in = 4'b1000;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_idle("abort");
    repeat (2) @(negedge clock);
    chk("abort_no_done", {31'h0, done}, 32'h0);
    reset_n = 1'b1;

    run_op("after_rst", 2'd0, 16'h1234, 16'h4321, 4'b0000, 16'h5555, 4'b0000, ALU_ADD);
    repeat (4) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
